spi_protocol_monitor: RTL

- Parametrised, clock-sampled SPI protocol monitor.
- Successor to the Mode-0-only, single-byte bench checker.
- Supports all four CPOL/CPHA modes, configurable header/data widths and multi-frame bursts.
- Reports decoded transactions and sticky protocol errors as registered outputs. Used both on bench SPI buses and as an on-chip debug tap beside the SPI master.

---
 rtl/spi_mon_pkg.sv | 20 ++
 rtl/spi_pin_sync.sv | 80 ++++++++
 rtl/spi_protocol_monitor.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_mon_pkg.sv
// Shared types and constants for the SPI protocol monitor.
// Error flag bit positions are fixed so software decoding stays stable across builds.
package spi_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_t;

    localparam int ERR_SCK_IDLE  = 0;
    localparam int ERR_PARTIAL   = 1;
    localparam int ERR_TIMEOUT   = 2;
    localparam int ERR_SCK_NO_CS = 3;

    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return cpol == cpha;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Pin synchronizer: SYNC_STAGES flops per input, then one aligned level/edge register.
// Levels and edge strobes leave together, SYNC_STAGES+1 cycles after the pin changes.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit SCK_IDLE    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic cs_n,
    input  logic sck,
    input  logic mosi,
    input  logic miso,
    output logic cs_n_s,
    output logic sck_s,
    output logic mosi_s,
    output logic miso_s,
    output logic cs_fall,
    output logic cs_rise,
    output logic sck_rise,
    output logic sck_fall
);

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_miso_sync;
    logic r_cs_lvl, r_sck_lvl, r_mosi_lvl, r_miso_lvl;
    logic r_cs_fall, r_cs_rise, r_sck_rise, r_sck_fall;
    logic w_cs_last, w_sck_last;

    assign w_cs_last  = r_cs_sync[SYNC_STAGES-1];
    assign w_sck_last = r_sck_sync[SYNC_STAGES-1];

    // Reset to the bus idle levels so leaving reset never fabricates an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_sync   <= '1;
            r_sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
            r_mosi_sync <= '0;
            r_miso_sync <= '0;
            r_cs_lvl    <= 1'b1;
            r_sck_lvl   <= SCK_IDLE;
            r_mosi_lvl  <= 1'b0;
            r_miso_lvl  <= 1'b0;
            r_cs_fall   <= 1'b0;
            r_cs_rise   <= 1'b0;
            r_sck_rise  <= 1'b0;
            r_sck_fall  <= 1'b0;
        end else begin
            r_cs_sync[0]   <= cs_n;
            r_sck_sync[0]  <= sck;
            r_mosi_sync[0] <= mosi;
            r_miso_sync[0] <= miso;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_cs_sync[i]   <= r_cs_sync[i-1];
                r_sck_sync[i]  <= r_sck_sync[i-1];
                r_mosi_sync[i] <= r_mosi_sync[i-1];
                r_miso_sync[i] <= r_miso_sync[i-1];
            end
            r_cs_lvl   <= w_cs_last;
            r_sck_lvl  <= w_sck_last;
            r_mosi_lvl <= r_mosi_sync[SYNC_STAGES-1];
            r_miso_lvl <= r_miso_sync[SYNC_STAGES-1];
            r_cs_fall  <= r_cs_lvl & ~w_cs_last;
            r_cs_rise  <= ~r_cs_lvl & w_cs_last;
            r_sck_rise <= ~r_sck_lvl & w_sck_last;
            r_sck_fall <= r_sck_lvl & ~w_sck_last;
        end
    end

    assign cs_n_s   = r_cs_lvl;
    assign sck_s    = r_sck_lvl;
    assign mosi_s   = r_mosi_lvl;
    assign miso_s   = r_miso_lvl;
    assign cs_fall  = r_cs_fall;
    assign cs_rise  = r_cs_rise;
    assign sck_rise = r_sck_rise;
    assign sck_fall = r_sck_fall;

endmodule

// File: rtl/spi_protocol_monitor.sv
// Clock-sampled SPI monitor: decodes header/data frames in any CPOL/CPHA mode
// and reports sticky protocol errors with a saturating event count.
module spi_protocol_monitor
    import spi_mon_pkg::*;
#(
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int MAX_FRAMES  = 16,
    parameter int TIMEOUT_CYC = 4096,
    parameter int SYNC_STAGES = 2,
    localparam int FR_W       = $clog2(MAX_FRAMES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cs_n,
    input  logic              sck,
    input  logic              mosi,
    input  logic              miso,
    input  logic              clr_err,
    output logic              hdr_valid,
    output logic              txn_rw,
    output logic [ADDR_W-2:0] txn_addr,
    output logic              frame_valid,
    output logic [DATA_W-1:0] frame_data,
    output logic              txn_done,
    output logic [FR_W-1:0]   txn_frames,
    output logic [3:0]        err_flags,
    output logic [15:0]       err_count
);

    localparam int   SH_W        = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int   CNT_W       = $clog2(SH_W + 1);
    localparam int   TO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    logic w_cs_n_s, w_sck_s, w_mosi_s, w_miso_s;
    logic w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .SCK_IDLE    (CPOL)
    ) u_pin_sync (
        .clk      (clk),
        .rst      (rst),
        .cs_n     (cs_n),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso),
        .cs_n_s   (w_cs_n_s),
        .sck_s    (w_sck_s),
        .mosi_s   (w_mosi_s),
        .miso_s   (w_miso_s),
        .cs_fall  (w_cs_fall),
        .cs_rise  (w_cs_rise),
        .sck_rise (w_sck_rise),
        .sck_fall (w_sck_fall)
    );

    state_t            r_state, w_state_next;
    logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_next;
    logic [SH_W-1:0]   r_shift, w_shift_next;
    logic [FR_W-1:0]   r_frame_cnt, w_frame_cnt_next;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_idle_cond, w_idle_cond;
    logic              w_sample, w_active, w_start, w_shift_en, w_bit_in;
    logic              w_hdr_done, w_frame_done, w_cs_end;
    logic [3:0]        w_err_new;
    logic [2:0]        w_err_inc;
    logic [16:0]       w_cnt_sum;

    logic              r_hdr_valid, r_txn_rw, r_frame_valid, r_txn_done;
    logic [ADDR_W-2:0] r_txn_addr;
    logic [DATA_W-1:0] r_frame_data;
    logic [FR_W-1:0]   r_txn_frames;
    logic [3:0]        r_err_flags;
    logic [15:0]       r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_cs_fall) w_state_next = HEADER;
                HEADER: begin
                    if (w_cs_rise)       w_state_next = IDLE;
                    else if (w_hdr_done) w_state_next = DATA;
                end
                DATA:    if (w_cs_rise) w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // A sample edge coinciding with CS_N rise is shifted first, so the partial
    // check looks at the post-shift bit count.
    always_comb begin
        w_sample     = SAMPLE_RISE ? w_sck_rise : w_sck_fall;
        w_active     = enable && (r_state != IDLE);
        w_start      = enable && (r_state == IDLE) && w_cs_fall;
        w_shift_en   = w_active && w_sample;
        w_bit_in     = ((r_state == DATA) && r_txn_rw) ? w_miso_s : w_mosi_s;
        w_shift_next = {r_shift[SH_W-2:0], w_bit_in};
        w_hdr_done   = w_shift_en && (r_state == HEADER) && (r_bit_cnt == CNT_W'(ADDR_W - 1));
        w_frame_done = w_shift_en && (r_state == DATA) && (r_bit_cnt == CNT_W'(DATA_W - 1));
        w_cs_end     = w_active && w_cs_rise;

        w_bit_cnt_next = r_bit_cnt;
        if (w_start) begin
            w_bit_cnt_next = '0;
        end else if (w_shift_en) begin
            w_bit_cnt_next = (w_hdr_done || w_frame_done) ? '0 : r_bit_cnt + CNT_W'(1);
        end

        w_frame_cnt_next = r_frame_cnt;
        if (w_start) begin
            w_frame_cnt_next = '0;
        end else if (w_frame_done && (r_frame_cnt != FR_W'(MAX_FRAMES))) begin
            w_frame_cnt_next = r_frame_cnt + FR_W'(1);
        end

        // An SCK edge leaving idle with CS_N high is reported once, as sck_idle.
        w_idle_cond = w_cs_n_s && (w_sck_s != CPOL);
        w_err_new = '0;
        w_err_new[ERR_SCK_IDLE]  = enable && w_idle_cond && !r_idle_cond;
        w_err_new[ERR_PARTIAL]   = w_cs_end &&
                                   (((r_state == HEADER) && !w_hdr_done) || (w_bit_cnt_next != '0));
        w_err_new[ERR_TIMEOUT]   = w_active && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
        w_err_new[ERR_SCK_NO_CS] = enable && w_sample && w_cs_n_s && !w_cs_rise &&
                                   !w_err_new[ERR_SCK_IDLE];

        w_err_inc = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_err_inc = w_err_inc + 3'(w_err_new[i]);
        end
        w_cnt_sum = {1'b0, r_err_count} + 17'(w_err_inc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_frame_cnt   <= '0;
            r_to_cnt      <= '0;
            r_idle_cond   <= 1'b0;
            r_hdr_valid   <= 1'b0;
            r_txn_rw      <= 1'b0;
            r_txn_addr    <= '0;
            r_frame_valid <= 1'b0;
            r_frame_data  <= '0;
            r_txn_done    <= 1'b0;
            r_txn_frames  <= '0;
            r_err_flags   <= '0;
            r_err_count   <= '0;
        end else begin
            r_bit_cnt     <= w_bit_cnt_next;
            r_frame_cnt   <= w_frame_cnt_next;
            r_idle_cond   <= w_idle_cond;
            r_hdr_valid   <= w_hdr_done;
            r_frame_valid <= w_frame_done;
            r_txn_done    <= w_cs_end;
            if (w_shift_en) begin
                r_shift <= w_shift_next;
            end
            if (w_start) begin
                r_to_cnt <= '0;
            end else if (w_active && (r_to_cnt != TO_W'(TIMEOUT_CYC))) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_hdr_done) begin
                r_txn_rw   <= w_shift_next[ADDR_W-1];
                r_txn_addr <= w_shift_next[ADDR_W-2:0];
            end
            if (w_frame_done) begin
                r_frame_data <= w_shift_next[DATA_W-1:0];
            end
            if (w_cs_end) begin
                r_txn_frames <= w_frame_cnt_next;
            end
            if (clr_err) begin
                r_err_flags <= w_err_new;
                r_err_count <= {13'd0, w_err_inc};
            end else begin
                r_err_flags <= r_err_flags | w_err_new;
                r_err_count <= w_cnt_sum[16] ? '1 : w_cnt_sum[15:0];
            end
        end
    end

    assign hdr_valid   = r_hdr_valid;
    assign txn_rw      = r_txn_rw;
    assign txn_addr    = r_txn_addr;
    assign frame_valid = r_frame_valid;
    assign frame_data  = r_frame_data;
    assign txn_done    = r_txn_done;
    assign txn_frames  = r_txn_frames;
    assign err_flags   = r_err_flags;
    assign err_count   = r_err_count;

endmodule
